// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the two-requester memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [0:0] {
    SERVE = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_ADDR_W = 4;
  localparam int NUM_REQ        = 2;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response bus between the two requesters and mem_port_arbiter.
// Handshake: a request on port i is accepted at a rising edge where req_valid[i]
// and req_ready[i] are both high; an unserved requester keeps valid and its
// fields stable until ready. Read data arrives as a one-cycle rsp_valid[i] pulse.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] req_we;
  logic [ADDR_W-1:0]  req_addr0;
  logic [ADDR_W-1:0]  req_addr1;
  logic [DATA_W-1:0]  req_wdata0;
  logic [DATA_W-1:0]  req_wdata1;
  logic [NUM_REQ-1:0] rsp_valid;
  logic [DATA_W-1:0]  rsp_rdata0;
  logic [DATA_W-1:0]  rsp_rdata1;

  modport master (
    output req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
    input  req_ready, rsp_valid, rsp_rdata0, rsp_rdata1
  );

  modport slave (
    input  req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
    output req_ready, rsp_valid, rsp_rdata0, rsp_rdata1
  );
endinterface

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter; on contention the requester that did not win
// last time is granted. rr_last resets to 1 so requester 0 wins first.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] request,
  input  logic               update_en,
  output logic [NUM_REQ-1:0] grant
);
  logic rr_last_q, rr_last_d;

  always_comb begin
    grant     = 2'b00;
    rr_last_d = rr_last_q;
    case (request)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_last_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
    if (update_en && (grant != 2'b00)) rr_last_d = grant[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_last_q <= 1'b1;
    else     rr_last_q <= rr_last_d;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin access to a private register array, with a sequenced
// clear that walks every address while both requesters are stalled.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus,
  input  logic                clear_start,
  output logic                busy,
  output logic                clear_done,
  output logic [CNT_W-1:0]    grant_cnt0,
  output logic [CNT_W-1:0]    grant_cnt1,
  output state_t              dbg_state
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [0:0] ST_SERVE = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [ADDR_W-1:0]  clear_ptr_q, clear_ptr_d;
  logic               clear_done_q, clear_done_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata0_q, rsp_rdata0_d;
  logic [DATA_W-1:0]  rsp_rdata1_q, rsp_rdata1_d;
  logic [CNT_W-1:0]   grant_cnt0_q, grant_cnt0_d;
  logic [CNT_W-1:0]   grant_cnt1_q, grant_cnt1_d;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [DATA_W-1:0]  mem_wdata;

  logic               in_serve;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] hs;

  assign in_serve = (state_q == ST_SERVE);

  // Requests are masked during CLEAR so the arbiter never grants there.
  rr_arbiter2 u_rr (
    .clk       (clk),
    .rst       (rst),
    .request   (bus.req_valid & {NUM_REQ{in_serve}}),
    .update_en (in_serve),
    .grant     (grant)
  );

  assign hs = bus.req_valid & grant;

  always_comb begin
    state_d      = state_q;
    clear_ptr_d  = clear_ptr_q;
    clear_done_d = 1'b0;
    rsp_valid_d  = '0;
    rsp_rdata0_d = rsp_rdata0_q;
    rsp_rdata1_d = rsp_rdata1_q;
    grant_cnt0_d = grant_cnt0_q;
    grant_cnt1_d = grant_cnt1_q;
    mem_we       = 1'b0;
    mem_waddr    = clear_ptr_q;
    mem_wdata    = '0;

    case (state_q)
      ST_SERVE: begin
        if (hs[0]) begin
          grant_cnt0_d = grant_cnt0_q + CNT_W'(1);
          if (bus.req_we[0]) begin
            mem_we    = 1'b1;
            mem_waddr = bus.req_addr0;
            mem_wdata = bus.req_wdata0;
          end else begin
            rsp_valid_d[0] = 1'b1;
            rsp_rdata0_d   = mem[bus.req_addr0];
          end
        end
        if (hs[1]) begin
          grant_cnt1_d = grant_cnt1_q + CNT_W'(1);
          if (bus.req_we[1]) begin
            mem_we    = 1'b1;
            mem_waddr = bus.req_addr1;
            mem_wdata = bus.req_wdata1;
          end else begin
            rsp_valid_d[1] = 1'b1;
            rsp_rdata1_d   = mem[bus.req_addr1];
          end
        end
        // The same-cycle handshake above still completes before the clear.
        if (clear_start) begin
          state_d     = ST_CLEAR;
          clear_ptr_d = '0;
        end
      end
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clear_ptr_q;
        if (clear_ptr_q == {ADDR_W{1'b1}}) begin
          state_d      = ST_SERVE;
          clear_done_d = 1'b1;
          clear_ptr_d  = '0;
        end else begin
          clear_ptr_d = clear_ptr_q + ADDR_W'(1);
        end
      end
      default: state_d = ST_SERVE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_SERVE;
      clear_ptr_q  <= '0;
      clear_done_q <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_rdata0_q <= '0;
      rsp_rdata1_q <= '0;
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
    end else begin
      state_q      <= state_d;
      clear_ptr_q  <= clear_ptr_d;
      clear_done_q <= clear_done_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata0_q <= rsp_rdata0_d;
      rsp_rdata1_q <= rsp_rdata1_d;
      grant_cnt0_q <= grant_cnt0_d;
      grant_cnt1_q <= grant_cnt1_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign bus.req_ready  = grant;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata0 = rsp_rdata0_q;
  assign bus.rsp_rdata1 = rsp_rdata1_q;
  assign busy           = (state_q == ST_CLEAR);
  assign clear_done     = clear_done_q;
  assign grant_cnt0     = grant_cnt0_q;
  assign grant_cnt1     = grant_cnt1_q;
  assign dbg_state      = state_t'(state_q);
endmodule
